// File: rtl/xyolo_mac_stage.sv
// Per-lane multiply-accumulate stage: shared pixel times per-lane weight over a
// configured sample count, then shift, bias add, saturate and optional leaky ReLU.
`timescale 1ns/1ps
`ifndef nYOLOvect
`define nYOLOvect 4
`endif

module xyolo_mac_stage #(
  parameter int DATAPATH_W = 16,
  parameter int N_LANES    = `nYOLOvect,
  parameter int ACC_W      = 40,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            run,
  output logic                            done,
  input  logic                            valid,
  input  logic [1:0]                      addr,
  input  logic [CNT_W-1:0]                wdata,
  input  logic                            wstrb,
  input  logic                            in_en,
  input  logic [DATAPATH_W-1:0]           flow_in_pixel,
  input  logic [N_LANES*DATAPATH_W-1:0]   flow_in_weight,
  input  logic [N_LANES*DATAPATH_W-1:0]   flow_in_bias,
  output logic [N_LANES*DATAPATH_W-1:0]   flow_out,
  output logic                            out_valid
);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_RESULT, S_OUT} state_t;

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-DATAPATH_W+2){1'b0}}, {(DATAPATH_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-DATAPATH_W+2){1'b1}}, {(DATAPATH_W-1){1'b0}}};

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0] r_conf_iter, r_sh_iter, r_cnt, w_cnt_inc;
  logic [4:0]       r_conf_shift, r_sh_shift;
  logic             r_conf_bias_en, r_sh_bias_en;
  logic             r_conf_leaky, r_sh_leaky;
  logic             r_prod_vld;

  logic signed [2*DATAPATH_W-1:0] w_pix_x;
  logic signed [2*DATAPATH_W-1:0] w_wgt_x   [N_LANES];
  logic signed [DATAPATH_W-1:0]   w_bias_in [N_LANES];
  logic signed [2*DATAPATH_W-1:0] r_prod    [N_LANES];
  logic signed [DATAPATH_W-1:0]   r_bias    [N_LANES];
  logic signed [ACC_W-1:0]        r_acc     [N_LANES];
  logic signed [ACC_W-1:0]        w_shift   [N_LANES];
  logic signed [ACC_W:0]          w_bias_sel[N_LANES];
  logic signed [ACC_W:0]          w_sum     [N_LANES];
  logic signed [DATAPATH_W-1:0]   w_sat     [N_LANES];
  logic signed [DATAPATH_W-1:0]   w_res     [N_LANES];
  logic [N_LANES*DATAPATH_W-1:0]  r_flow_out;

  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_pix_x   = {{DATAPATH_W{flow_in_pixel[DATAPATH_W-1]}}, flow_in_pixel};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conf_iter    <= '0;
      r_conf_shift   <= '0;
      r_conf_bias_en <= 1'b0;
      r_conf_leaky   <= 1'b0;
    end else if (clear) begin
      r_conf_iter    <= '0;
      r_conf_shift   <= '0;
      r_conf_bias_en <= 1'b0;
      r_conf_leaky   <= 1'b0;
    end else if (valid && wstrb) begin
      case (addr)
        2'd0:    r_conf_iter    <= wdata;
        2'd1:    r_conf_shift   <= wdata[4:0];
        2'd2:    r_conf_bias_en <= wdata[0];
        default: r_conf_leaky   <= wdata[0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (run && (r_conf_iter != '0)) w_state_nxt = S_ACC;
      S_ACC:    if (in_en && (w_cnt_inc == r_sh_iter)) w_state_nxt = S_DRAIN;
      S_DRAIN:  w_state_nxt = S_RESULT;
      S_RESULT: w_state_nxt = S_OUT;
      S_OUT:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign done      = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign flow_out  = r_flow_out;

  // Lane 0 occupies the most significant slice of every packed lane bus.
  always_comb begin
    for (int unsigned l = 0; l < N_LANES; l++) begin
      w_wgt_x[l]    = {{DATAPATH_W{flow_in_weight[(N_LANES-1-l)*DATAPATH_W+DATAPATH_W-1]}},
                       flow_in_weight[(N_LANES-1-l)*DATAPATH_W +: DATAPATH_W]};
      w_bias_in[l]  = flow_in_bias[(N_LANES-1-l)*DATAPATH_W +: DATAPATH_W];
      w_shift[l]    = r_acc[l] >>> r_sh_shift;
      w_bias_sel[l] = r_sh_bias_en ? (ACC_W+1)'(r_bias[l]) : '0;
      w_sum[l]      = (ACC_W+1)'(w_shift[l]) + w_bias_sel[l];
      if (w_sum[l] > SAT_MAX)      w_sat[l] = {1'b0, {(DATAPATH_W-1){1'b1}}};
      else if (w_sum[l] < SAT_MIN) w_sat[l] = {1'b1, {(DATAPATH_W-1){1'b0}}};
      else                         w_sat[l] = w_sum[l][DATAPATH_W-1:0];
      w_res[l]      = (r_sh_leaky && w_sat[l][DATAPATH_W-1]) ? (w_sat[l] >>> 3) : w_sat[l];
    end
  end

  // Product is registered one cycle ahead of the accumulate; DRAIN absorbs the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_iter    <= '0;
      r_sh_shift   <= '0;
      r_sh_bias_en <= 1'b0;
      r_sh_leaky   <= 1'b0;
      r_cnt        <= '0;
      r_prod_vld   <= 1'b0;
      r_flow_out   <= '0;
      for (int unsigned l = 0; l < N_LANES; l++) begin
        r_prod[l] <= '0;
        r_bias[l] <= '0;
        r_acc[l]  <= '0;
      end
    end else begin
      r_prod_vld <= (r_state == S_ACC) && in_en;
      if (r_state == S_IDLE && run) begin
        r_sh_iter    <= r_conf_iter;
        r_sh_shift   <= r_conf_shift;
        r_sh_bias_en <= r_conf_bias_en;
        r_sh_leaky   <= r_conf_leaky;
        r_cnt        <= '0;
      end else if (r_state == S_ACC && in_en) begin
        r_cnt <= w_cnt_inc;
      end
      for (int unsigned l = 0; l < N_LANES; l++) begin
        if (r_state == S_ACC && in_en) begin
          r_prod[l] <= w_pix_x * w_wgt_x[l];
          r_bias[l] <= w_bias_in[l];
        end
        if (r_state == S_IDLE && run)  r_acc[l] <= '0;
        else if (r_prod_vld)           r_acc[l] <= r_acc[l] + ACC_W'(r_prod[l]);
        if (r_state == S_RESULT)
          r_flow_out[(N_LANES-1-l)*DATAPATH_W +: DATAPATH_W] <= w_res[l];
      end
    end
  end

endmodule

// File: tb/tb_xyolo_mac_stage.sv
// Bench for xyolo_mac_stage: directed table, control sequences and random jobs
// checked against an integer-arithmetic model of the result formula.
`timescale 1ns/1ps

module tb_xyolo_mac_stage;

  logic        clk = 1'b0;
  logic        rst, clear, run, valid, wstrb, in_en;
  logic [1:0]  addr;
  logic [15:0] wdata, pixel;
  logic [63:0] weight, bias, flow_out;
  logic        done, out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0]      iter;
    logic [4:0]       shift;
    logic             bias_en;
    logic             leaky;
    logic             mid_run;
    logic [7:0][1:0]  gap;
    logic [7:0][15:0] pix;
    logic [7:0][63:0] wt;
    logic [63:0]      bias;
    logic [63:0]      exp;
  } vec_t;

  vec_t tbl [6];

  xyolo_mac_stage #(.DATAPATH_W(16), .N_LANES(4), .ACC_W(40), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .run(run), .done(done),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .in_en(in_en), .flow_in_pixel(pixel), .flow_in_weight(weight),
    .flow_in_bias(bias), .flow_out(flow_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic longint sx(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  function automatic logic [63:0] model(input vec_t v);
    logic [63:0] res;
    longint acc, r;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      acc = 0;
      for (int i = 0; i < int'(v.iter); i++)
        acc += sx(v.pix[i]) * sx(v.wt[i][(3-l)*16 +: 16]);
      r = (acc >>> v.shift) + (v.bias_en ? sx(v.bias[(3-l)*16 +: 16]) : 64'sd0);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      if (v.leaky && r < 0) r = r >>> 3;
      res[(3-l)*16 +: 16] = 16'(r);
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
    tick();
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic apply_job(input vec_t v, input bit skip_cfg, input string name);
    int seen, c;
    logic [63:0] got;
    if (!skip_cfg) begin
      cfg_write(2'd0, v.iter);
      cfg_write(2'd1, {11'd0, v.shift});
      cfg_write(2'd2, {15'd0, v.bias_en});
      cfg_write(2'd3, {15'd0, v.leaky});
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    check({name, " busy"}, {63'd0, done}, 64'd0);
    for (int i = 0; i < int'(v.iter); i++) begin
      for (int g = 0; g < int'(v.gap[i]); g++) begin
        in_en = 1'b0; pixel = 16'($urandom);
        weight = {$urandom, $urandom}; bias = {$urandom, $urandom};
        tick();
      end
      in_en = 1'b1; pixel = v.pix[i]; weight = v.wt[i];
      bias = (i == int'(v.iter) - 1) ? v.bias : {$urandom, $urandom};
      if (v.mid_run && i > 0) begin
        run = 1'b1; valid = 1'b1; wstrb = 1'b1; addr = 2'd1; wdata = 16'd9;
      end
      tick();
      run = 1'b0; valid = 1'b0; wstrb = 1'b0;
    end
    seen = 0; c = 1; got = 'x;
    while (c <= 8 && seen == 0) begin
      if (out_valid) begin
        seen = c; got = flow_out;
        if (v.mid_run) run = 1'b1;
      end else begin
        in_en = 1'b1; pixel = 16'($urandom); weight = {$urandom, $urandom};
        tick();
        c++;
      end
    end
    check({name, " latency"}, 64'(seen), 64'd3);
    check({name, " result"}, got, v.exp);
    in_en = 1'b0;
    tick();
    run = 1'b0;
    check({name, " done/out_valid after"}, {62'd0, done, out_valid}, 64'b10);
    check({name, " hold"}, flow_out, got);
  endtask

  task automatic check_noop(input string name, input logic [63:0] held);
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (!done || out_valid) bad++;
      tick();
    end
    check({name, " no activity"}, 64'(bad), 64'd0);
    check({name, " flow_out held"}, flow_out, held);
  endtask

  task automatic fill_table();
    for (int t = 0; t < 6; t++) tbl[t] = '0;
    tbl[0].iter = 16'd3;
    for (int i = 0; i < 3; i++) begin
      tbl[0].pix[i] = 16'd2;
      tbl[0].wt[i]  = {16'(i + 1), 48'h0};
    end
    tbl[0].exp = {16'd12, 48'h0};

    tbl[1].iter = 16'd2; tbl[1].shift = 5'd4; tbl[1].bias_en = 1'b1;
    tbl[1].gap[1] = 2'd2;
    for (int i = 0; i < 2; i++) begin
      tbl[1].pix[i] = 16'd100;
      tbl[1].wt[i]  = {4{16'd100}};
    end
    tbl[1].bias = {4{16'd7}};
    tbl[1].exp  = {4{16'd1257}};

    tbl[2].iter = 16'd4;
    for (int i = 0; i < 4; i++) begin
      tbl[2].pix[i] = 16'h7fff;
      tbl[2].wt[i]  = {16'h7fff, 16'h8000, 16'h7fff, 16'h8000};
    end
    tbl[2].exp = {16'h7fff, 16'h8000, 16'h7fff, 16'h8000};

    tbl[3].iter = 16'd1; tbl[3].leaky = 1'b1;
    tbl[3].pix[0] = 16'hffb0;
    tbl[3].wt[0]  = {16'd1, 16'd2, 16'hffff, 16'd0};
    tbl[3].exp    = {16'hfff6, 16'hffec, 16'h0050, 16'h0000};

    tbl[4] = tbl[3];
    tbl[4].leaky = 1'b0;
    tbl[4].exp   = {16'hffb0, 16'hff60, 16'h0050, 16'h0000};

    tbl[5] = tbl[0];
    tbl[5].mid_run = 1'b1;
  endtask

  initial begin
    vec_t rv;
    rst = 1'b0; clear = 1'b0; run = 1'b0; valid = 1'b0; wstrb = 1'b0;
    in_en = 1'b0; addr = '0; wdata = '0; pixel = '0; weight = '0; bias = '0;
    fill_table();
    #2;
    check("reset flow_out", flow_out, 64'd0);
    check("reset done/out_valid", {62'd0, done, out_valid}, 64'b10);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int t = 0; t < 6; t++) apply_job(tbl[t], 1'b0, $sformatf("table%0d", t));
    apply_job(tbl[2], 1'b0, "sat first");
    apply_job(tbl[2], 1'b1, "run at done rise");

    cfg_write(2'd0, 16'd0);
    run = 1'b1; tick(); run = 1'b0;
    check_noop("iter0", tbl[2].exp);

    cfg_write(2'd0, 16'd3);
    clear = 1'b1; tick(); clear = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    check_noop("clear", tbl[2].exp);

    cfg_write(2'd0, 16'd3);
    run = 1'b1; tick(); run = 1'b0;
    in_en = 1'b1; pixel = 16'd5; weight = {4{16'd5}};
    tick();
    rst = 1'b0;
    in_en = 1'b0;
    #1;
    check("mid reset flow_out", flow_out, 64'd0);
    check("mid reset done/out_valid", {62'd0, done, out_valid}, 64'b10);
    @(negedge clk);
    rst = 1'b1;
    tick();
    apply_job(tbl[0], 1'b0, "after reset");

    for (int n = 0; n < 40; n++) begin
      rv = '0;
      rv.iter    = 16'($urandom_range(1, 8));
      rv.shift   = 5'($urandom_range(0, 20));
      rv.bias_en = 1'($urandom);
      rv.leaky   = 1'($urandom);
      rv.bias    = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) begin
        rv.gap[i] = 2'($urandom_range(0, 2));
        rv.pix[i] = 16'($urandom);
        rv.wt[i]  = {$urandom, $urandom};
      end
      rv.exp = model(rv);
      apply_job(rv, 1'b0, $sformatf("random%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
